// File: rtl/mem_port_arbiter.sv
// Shares one memory port between a CPU and a ones'-complement counter
// increment unit; the counter has priority but never starves the CPU.
module mem_port_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [2:0]  cpu_eBank,
  input  logic [4:0]  cpu_fBank,
  input  logic        cpu_superBank,
  input  logic [11:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_ack,
  output logic [15:0] cpu_rdata,
  input  logic        ctr_req,
  input  logic        ctr_op,
  input  logic [11:0] ctr_addr,
  output logic        ctr_ack,
  output logic        ctr_ovf,
  output logic [2:0]  mem_eBank,
  output logic [4:0]  mem_fBank,
  output logic        mem_superBank,
  output logic [11:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  input  logic [15:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_CPU = 2'd1,
    CTR_RD  = 2'd2,
    CTR_WR  = 2'd3
  } state_t;

  state_t      state_r, nextState_s;
  logic        cpuElig_s, ctrElig_s, grantCpu_s, grantCtr_s;
  logic        lastCtr_r, lastCtr_s;
  logic        ctrOp_r, ctrOp_s;
  logic        ovf_r, ovf_s;
  logic [15:0] step_s;
  logic [2:0]  memEBank_s;
  logic [4:0]  memFBank_s;
  logic        memSuperBank_s;
  logic [11:0] memAddr_s;
  logic [15:0] memWdata_s;
  logic        memWe_s;
  logic        cpuAck_s, ctrAck_s, ctrOvf_s;
  logic [15:0] cpuRdata_s;

  // 15-bit ones'-complement +1/-1; result is {overflow, 15-bit value}
  function automatic logic [15:0] onesCompStep(input logic minc, input logic [14:0] v);
    logic [15:0] res;
    if (minc) begin
      if (v == 15'h4000)      res = {1'b1, 15'h7FFF};
      else if (v == 15'h0000) res = {1'b0, 15'h7FFE};
      else                    res = {1'b0, v - 15'd1};
    end else begin
      if (v == 15'h3FFF)      res = {1'b1, 15'h0000};
      else if (v == 15'h7FFF) res = {1'b0, 15'h0001};
      else                    res = {1'b0, v + 15'd1};
    end
    return res;
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= nextState_s;
  end

  // Arbitration and next-state selection
  always_comb begin
    cpuElig_s   = cpu_req & ~cpu_ack;
    ctrElig_s   = ctr_req & ~ctr_ack;
    grantCtr_s  = 1'b0;
    grantCpu_s  = 1'b0;
    nextState_s = state_r;
    case (state_r)
      IDLE: begin
        // a counter grant last time hands this arbitration to a waiting CPU
        if (ctrElig_s && !(lastCtr_r && cpuElig_s)) begin
          grantCtr_s  = 1'b1;
          nextState_s = CTR_RD;
        end else if (cpuElig_s) begin
          grantCpu_s  = 1'b1;
          nextState_s = GNT_CPU;
        end else begin
          nextState_s = IDLE;
        end
      end
      GNT_CPU: nextState_s = IDLE;
      CTR_RD:  nextState_s = CTR_WR;
      CTR_WR:  nextState_s = IDLE;
      default: nextState_s = IDLE;
    endcase
  end

  // Next values for the registered memory port, acks and internal latches
  always_comb begin
    memEBank_s     = 3'd0;
    memFBank_s     = 5'd0;
    memSuperBank_s = 1'b0;
    memAddr_s      = 12'd0;
    memWdata_s     = 16'd0;
    memWe_s        = 1'b0;
    cpuAck_s       = 1'b0;
    ctrAck_s       = 1'b0;
    ctrOvf_s       = 1'b0;
    lastCtr_s      = lastCtr_r;
    ctrOp_s        = ctrOp_r;
    ovf_s          = ovf_r;
    step_s         = onesCompStep(ctrOp_r, mem_rdata[14:0]);
    case (nextState_s)
      GNT_CPU: begin
        memEBank_s     = cpu_eBank;
        memFBank_s     = cpu_fBank;
        memSuperBank_s = cpu_superBank;
        memAddr_s      = cpu_addr;
        memWdata_s     = cpu_wdata;
        memWe_s        = cpu_we;
        lastCtr_s      = 1'b0;
      end
      CTR_RD: begin
        memAddr_s = ctr_addr;
        ctrOp_s   = ctr_op;
        lastCtr_s = 1'b1;
      end
      CTR_WR: begin
        memAddr_s  = mem_addr;
        memWe_s    = 1'b1;
        memWdata_s = {mem_rdata[15], step_s[14:0]};
        ovf_s      = step_s[15];
      end
      IDLE: begin
        cpuAck_s = (state_r == GNT_CPU);
        ctrAck_s = (state_r == CTR_WR);
        ctrOvf_s = (state_r == CTR_WR) && ovf_r;
      end
      default: begin
        memWe_s = 1'b0;
      end
    endcase
    if (state_r == GNT_CPU) cpuRdata_s = mem_rdata;
    else                    cpuRdata_s = cpu_rdata;
  end

  // Output and latch registers; reset drops mem_we without waiting for a clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_eBank     <= 3'd0;
      mem_fBank     <= 5'd0;
      mem_superBank <= 1'b0;
      mem_addr      <= 12'd0;
      mem_wdata     <= 16'd0;
      mem_we        <= 1'b0;
      cpu_ack       <= 1'b0;
      cpu_rdata     <= 16'd0;
      ctr_ack       <= 1'b0;
      ctr_ovf       <= 1'b0;
      lastCtr_r     <= 1'b0;
      ctrOp_r       <= 1'b0;
      ovf_r         <= 1'b0;
    end else begin
      mem_eBank     <= memEBank_s;
      mem_fBank     <= memFBank_s;
      mem_superBank <= memSuperBank_s;
      mem_addr      <= memAddr_s;
      mem_wdata     <= memWdata_s;
      mem_we        <= memWe_s;
      cpu_ack       <= cpuAck_s;
      cpu_rdata     <= cpuRdata_s;
      ctr_ack       <= ctrAck_s;
      ctr_ovf       <= ctrOvf_s;
      lastCtr_r     <= lastCtr_s;
      ctrOp_r       <= ctrOp_s;
      ovf_r         <= ovf_s;
    end
  end

endmodule
